dft_scheduler: RTL and testbench
================================

# dft_scheduler

Sequencing controller for the team's single-MAC DFT datapath. It captures one frame of `N_SAMPLES` input samples into the sample buffer over a valid/ready handshake. It then sweeps bins `k = 0 .. N_BINS-1`, driving the buffer read address, the twiddle-ROM address and the accumulator clear/enable strobes, and emits one `bin_valid` handshake per finished bin. It sits between the ADC sample stream and the MAC/magnitude datapath and contains no arithmetic beyond index counters.

## Interface
- `N_SAMPLES`, 1000: frame length; also the twiddle period.
- `N_BINS`, 500: bins computed per frame; 1 ≤ `N_BINS` ≤ `N_SAMPLES`.
- `SAMPLE_W`, 11: input sample width.
- `IDX_W`, 10: index width; must satisfy 2^`IDX_W` ≥ `N_SAMPLES`.
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ena`  in  1  global hold; when low, all registers freeze and all strobes are forced low.
- `start`  in  1  one-cycle pulse; begins a frame. Honoured only in IDLE.
- `in_valid`  in  1  input sample valid.
- `in_ready`  out  1  high only in LOAD with `ena` high.
- `in_sample`  in  `SAMPLE_W`  input sample.
- `buf_we`  out  1  buffer write strobe; equals `in_valid & in_ready`.
- `buf_waddr`  out  `IDX_W`  write address, equal to the load count n.
- `buf_wdata`  out  `SAMPLE_W`  pass-through of `in_sample`.
- `buf_raddr`  out  `IDX_W`  buffer read address, equal to n.
- `tw_addr`  out  `IDX_W`  twiddle ROM address, (k·n) mod `N_SAMPLES`.
- `acc_clr`  out  1  clear accumulator, one cycle per bin.
- `acc_en`  out  1  accumulate the buffer/ROM data presented this cycle.
- `bin_valid`  out  1  accumulator holds a finished bin.
- `bin_ready`  in  1  downstream consumed the bin.
- `bin_index`  out  `IDX_W`  k of the current or emitted bin.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the last bin handshake completes.

## Operation
- States: IDLE, LOAD, CLEAR, ACCUM, DRAIN, EMIT.
- IDLE → LOAD on `start`.
- LOAD:
  - Each `buf_we` writes to address n, then n increments.
  - When the write at n = `N_SAMPLES-1` occurs, set n=0 and k=0, then go to CLEAR.
  - `in_valid` may gap freely.
- CLEAR:
  - Assert `acc_clr`.
  - Set n=0 and tw=0, then go to ACCUM.
- ACCUM:
  - Present `buf_raddr`=n and `tw_addr`=tw.
  - Next cycle: n+1; tw ← tw+k, minus `N_SAMPLES` if the sum ≥ `N_SAMPLES`. The compare is done at `IDX_W`+1 bits.
  - After issuing n = `N_SAMPLES-1`, go to DRAIN.
- DRAIN: one cycle that lets the last read land (see `acc_en`), then go to EMIT.
- EMIT:
  - Hold `bin_valid`=1 and `bin_index`=k until `bin_ready`.
  - On the handshake: if k = `N_BINS-1`, pulse `done` and go to IDLE. Otherwise k+1 and go to CLEAR.
- `acc_en` is registered: it is 1 in the cycle after each ACCUM issue (1-cycle read latency of buffer and ROM). So `acc_en` is high in the first `N_SAMPLES-1` cycles after ACCUM entry and in DRAIN.
- Ignored inputs:
  - `start` outside IDLE.
  - `in_valid` outside LOAD.
  - `bin_ready` outside EMIT.
- `ena` low:
  - The state, n, k, tw and the `acc_en` pipeline register hold.
  - `in_ready`, `buf_we`, `acc_en`, `acc_clr`, `bin_valid` and `done` are driven 0.
  - Resumption is exact: no issue is lost or duplicated.

## Timing
- Reset values:
  - State is IDLE; n, k and tw are 0.
  - All outputs are 0, including `buf_waddr`, `buf_raddr`, `tw_addr` and `bin_index`.
- `rst` mid-frame aborts immediately; the buffer contents are don't-care.
- Load: at least `N_SAMPLES` cycles (exactly that with `in_valid` held high).
- Per bin with `bin_ready` held high: CLEAR 1 + ACCUM `N_SAMPLES` + DRAIN 1 + EMIT 1 = `N_SAMPLES`+3 cycles.
- `bin_valid` first rises `N_SAMPLES`+2 cycles after CLEAR entry.
- `start` to first `bin_valid`, with continuous input: `N_SAMPLES`+1+`N_SAMPLES`+2 cycles.
- `done` is high in the same cycle as the final `bin_valid & bin_ready`; the state is IDLE on the next cycle.
- A `start` in that next cycle is accepted.

## Structure
- Shared package `dft_pkg`:
  - State enum.
  - Default `N_SAMPLES`, `N_BINS`, `SAMPLE_W`, `IDX_W`.
  - Read-latency constant (1), also used by the MAC block.
- Sub-module `dft_twiddle_step`:
  - Holds tw.
  - Inputs: clear, step enable, k.
  - Output: tw, computed by the conditional-subtract modular add.
  - Instantiated once.

## Test plan
- Use `N_SAMPLES`=8 and `N_BINS`=4.
  - Stimulus: start, then 8 back-to-back samples 1..8.
  - Response: `buf_waddr` 0..7 with `buf_we` each cycle, then `acc_clr` once.
- Same configuration, addresses:
  - k=3: `tw_addr` sequence 0,3,6,1,4,7,2,5.
  - k=0: all zeros.
  - `acc_en` is exactly 8 cycles per bin, lagging the addresses by 1.
- `bin_ready` low for 5 cycles in EMIT:
  - `bin_valid` and `bin_index` stay stable.
  - No `acc_clr` until the handshake.
  - `done` follows the k=3 handshake.
- `ena` dropped for 3 cycles mid-ACCUM at n=4:
  - Strobes are 0 during the gap.
  - The `tw_addr` sequence resumes at n=5 with no gap or duplicate.
  - Bin total cycles are +3.
- `rst` pulsed in LOAD after 5 writes:
  - All outputs are 0 and the state is IDLE.
  - A new start reloads from address 0.
  - `start` during ACCUM has no effect.
- Default parameters with ramp input:
  - 500 `bin_valid` handshakes.
  - `bin_index` 0..499.
  - Frame length = 1000 + 500·1003 cycles with input and `bin_ready` held high.
  - k=499, n=999: `tw_addr` = (499·999) mod 1000 = 501.

Source files
------------

// File: rtl/dft_pkg.sv
// ============================================================================
// Module      : dft_pkg
// Description : Shared types and default sizing for the single-MAC DFT path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dft_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CLEAR = 3'd2,
        ST_ACCUM = 3'd3,
        ST_DRAIN = 3'd4,
        ST_EMIT  = 3'd5
    } dft_state_e;

    localparam int c_def_n_samples = 1000;
    localparam int c_def_n_bins    = 500;
    localparam int c_def_sample_w  = 11;
    localparam int c_def_idx_w     = 10;

    // Buffer and twiddle ROM both return data one cycle after the address.
    localparam int c_read_lat = 1;

endpackage

`default_nettype wire

// File: rtl/dft_twiddle_step.sv
// ============================================================================
// Module      : dft_twiddle_step
// Description : Twiddle index register, tw <- (tw + k) mod N_SAMPLES.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dft_twiddle_step
    import dft_pkg::*;
#(
    parameter int N_SAMPLES = c_def_n_samples,
    parameter int IDX_W     = c_def_idx_w
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             step,
    input  logic [IDX_W-1:0] k,
    output logic [IDX_W-1:0] tw
);

    localparam logic [IDX_W:0] c_modulus = (IDX_W+1)'(N_SAMPLES);

    logic [IDX_W-1:0] tw_q, tw_d;
    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_next;

    // Both operands are < N_SAMPLES, so one conditional subtract suffices.
    always_comb begin
        w_sum  = {1'b0, tw_q} + {1'b0, k};
        w_next = (w_sum >= c_modulus) ? IDX_W'(w_sum - c_modulus) : IDX_W'(w_sum);
        tw_d   = tw_q;
        if (clr) begin
            tw_d = '0;
        end else if (step) begin
            tw_d = w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tw_q <= '0;
        end else begin
            tw_q <= tw_d;
        end
    end

    assign tw = tw_q;

endmodule

`default_nettype wire

// File: rtl/dft_scheduler.sv
// ============================================================================
// Module      : dft_scheduler
// Description : Frame load and per-bin sweep sequencer for the DFT MAC path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dft_scheduler
    import dft_pkg::*;
#(
    parameter int N_SAMPLES = c_def_n_samples,
    parameter int N_BINS    = c_def_n_bins,
    parameter int SAMPLE_W  = c_def_sample_w,
    parameter int IDX_W     = c_def_idx_w
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SAMPLE_W-1:0] in_sample,
    output logic                buf_we,
    output logic [IDX_W-1:0]    buf_waddr,
    output logic [SAMPLE_W-1:0] buf_wdata,
    output logic [IDX_W-1:0]    buf_raddr,
    output logic [IDX_W-1:0]    tw_addr,
    output logic                acc_clr,
    output logic                acc_en,
    output logic                bin_valid,
    input  logic                bin_ready,
    output logic [IDX_W-1:0]    bin_index,
    output logic                busy,
    output logic                done
);

    localparam logic [IDX_W-1:0] c_last_n = IDX_W'(N_SAMPLES - 1);
    localparam logic [IDX_W-1:0] c_last_k = IDX_W'(N_BINS - 1);

    dft_state_e       state_q, state_d;
    logic [IDX_W-1:0] n_q, n_d;
    logic [IDX_W-1:0] k_q, k_d;
    logic             acc_en_q, acc_en_d;
    logic             w_tw_clr, w_tw_step;
    logic [IDX_W-1:0] w_tw;
    logic             w_load;

    dft_twiddle_step #(
        .N_SAMPLES (N_SAMPLES),
        .IDX_W     (IDX_W)
    ) u_twiddle (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_tw_clr),
        .step (w_tw_step),
        .k    (k_q),
        .tw   (w_tw)
    );

    // ena low freezes every register, including the acc_en pipeline stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            n_q      <= '0;
            k_q      <= '0;
            acc_en_q <= 1'b0;
        end else if (ena) begin
            state_q  <= state_d;
            n_q      <= n_d;
            k_q      <= k_d;
            acc_en_q <= acc_en_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        k_d       = k_q;
        acc_en_d  = 1'b0;
        w_tw_clr  = 1'b0;
        w_tw_step = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    n_d     = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    if (n_q == c_last_n) begin
                        n_d     = '0;
                        k_d     = '0;
                        state_d = ST_CLEAR;
                    end else begin
                        n_d = n_q + 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                n_d      = '0;
                w_tw_clr = ena;
                state_d  = ST_ACCUM;
            end
            ST_ACCUM: begin
                acc_en_d  = 1'b1;
                w_tw_step = ena;
                if (n_q == c_last_n) begin
                    n_d     = '0;
                    state_d = ST_DRAIN;
                end else begin
                    n_d = n_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                state_d = ST_EMIT;
            end
            ST_EMIT: begin
                if (bin_ready) begin
                    if (k_q == c_last_k) begin
                        k_d     = '0;
                        state_d = ST_IDLE;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = ST_CLEAR;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_load    = ena && (state_q == ST_LOAD);
        in_ready  = w_load;
        buf_we    = w_load && in_valid;
        buf_waddr = n_q;
        buf_wdata = in_sample;
        buf_raddr = n_q;
        tw_addr   = w_tw;
        acc_clr   = ena && (state_q == ST_CLEAR);
        acc_en    = ena && acc_en_q;
        bin_valid = ena && (state_q == ST_EMIT);
        bin_index = k_q;
        busy      = (state_q != ST_IDLE);
        done      = ena && (state_q == ST_EMIT) && bin_ready && (k_q == c_last_k);
    end

endmodule

`default_nettype wire

// File: tb/tb_dft_scheduler.sv
// ============================================================================
// Module      : tb_dft_scheduler
// Description : Directed self-checking bench for dft_scheduler (N=8, 4 bins).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dft_scheduler;

    localparam int N  = 8;
    localparam int NB = 4;
    localparam int SW = 11;
    localparam int IW = 10;

    logic          clk = 1'b0;
    logic          rst, ena, start, in_valid, bin_ready;
    logic [SW-1:0] in_sample;
    logic          in_ready, buf_we, acc_clr, acc_en, bin_valid, busy, done;
    logic [SW-1:0] buf_wdata;
    logic [IW-1:0] buf_waddr, buf_raddr, tw_addr, bin_index;

    logic          tw_clr, tw_step;
    logic [IW-1:0] tw_k, tw_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dft_scheduler #(
        .N_SAMPLES (N),
        .N_BINS    (NB),
        .SAMPLE_W  (SW),
        .IDX_W     (IW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sample (in_sample),
        .buf_we    (buf_we),
        .buf_waddr (buf_waddr),
        .buf_wdata (buf_wdata),
        .buf_raddr (buf_raddr),
        .tw_addr   (tw_addr),
        .acc_clr   (acc_clr),
        .acc_en    (acc_en),
        .bin_valid (bin_valid),
        .bin_ready (bin_ready),
        .bin_index (bin_index),
        .busy      (busy),
        .done      (done)
    );

    // Full-size twiddle stepper for the k=499 wrap case.
    dft_twiddle_step #(
        .N_SAMPLES (1000),
        .IDX_W     (IW)
    ) u_tw_full (
        .clk  (clk),
        .rst  (rst),
        .clr  (tw_clr),
        .step (tw_step),
        .k    (tw_k),
        .tw   (tw_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ena = 1'b1; start = 1'b0; in_valid = 1'b0; in_sample = '0;
        bin_ready = 1'b0; tw_clr = 1'b0; tw_step = 1'b0; tw_k = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, buf_we, acc_clr, acc_en, bin_valid, busy, done} !== 7'b0) begin
            failures++;
            $display("FAIL reset_strobes got=%b want=0000000",
                     {in_ready, buf_we, acc_clr, acc_en, bin_valid, busy, done});
        end
        checks++;
        if ({buf_waddr, buf_raddr, tw_addr, bin_index} !== '0) begin
            failures++;
            $display("FAIL reset_addr waddr=%0d raddr=%0d tw=%0d bin=%0d want all 0",
                     buf_waddr, buf_raddr, tw_addr, bin_index);
        end
        rst = 1'b0;
        tick();
        #2;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle busy=%b in_ready=%b want 0 0", busy, in_ready);
        end
    endtask

    // From IDLE: start pulse, then N back-to-back samples base+1..base+N.
    task automatic test_load(input int base);
        start = 1'b1;
        #2;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL load_idle busy=%b in_ready=%b want 0 0", busy, in_ready);
        end
        tick();
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            in_valid  = 1'b1;
            in_sample = SW'(base + i + 1);
            #2;
            checks++;
            if (buf_we !== 1'b1 || in_ready !== 1'b1 || buf_waddr !== IW'(i) ||
                buf_wdata !== SW'(base + i + 1)) begin
                failures++;
                $display("FAIL load_write i=%0d we=%b rdy=%b waddr=%0d wdata=%0d want 1 1 %0d %0d",
                         i, buf_we, in_ready, buf_waddr, buf_wdata, i, base + i + 1);
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Entered in the CLEAR cycle of bin k; returns in the cycle after the bin handshake.
    task automatic run_bin(input int k, input int ready_wait, input int ena_gap_n,
                           input bit noise_in_accum);
        #2;
        checks++;
        if (acc_clr !== 1'b1 || acc_en !== 1'b0 || bin_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL clear_cycle k=%0d clr=%b en=%b bv=%b busy=%b want 1 0 0 1",
                     k, acc_clr, acc_en, bin_valid, busy);
        end
        tick();
        for (int n = 0; n < N; n++) begin
            if (n == ena_gap_n) begin
                ena = 1'b0;
                for (int g = 0; g < 3; g++) begin
                    #2;
                    checks++;
                    if ({in_ready, buf_we, acc_en, acc_clr, bin_valid, done} !== 6'b0 ||
                        tw_addr !== IW'((k * n) % N) || buf_raddr !== IW'(n)) begin
                        failures++;
                        $display("FAIL ena_gap k=%0d g=%0d strobes=%b tw=%0d raddr=%0d want 0 %0d %0d",
                                 k, g, {in_ready, buf_we, acc_en, acc_clr, bin_valid, done},
                                 tw_addr, buf_raddr, (k * n) % N, n);
                    end
                    tick();
                end
                ena = 1'b1;
            end
            start    = noise_in_accum;
            in_valid = noise_in_accum;
            #2;
            checks++;
            if (buf_raddr !== IW'(n) || tw_addr !== IW'((k * n) % N) || acc_en !== (n != 0) ||
                acc_clr !== 1'b0 || bin_valid !== 1'b0 || buf_we !== 1'b0) begin
                failures++;
                $display("FAIL accum k=%0d n=%0d raddr=%0d tw=%0d en=%b clr=%b bv=%b we=%b want %0d %0d %b 0 0 0",
                         k, n, buf_raddr, tw_addr, acc_en, acc_clr, bin_valid, buf_we,
                         n, (k * n) % N, n != 0);
            end
            tick();
        end
        start    = 1'b0;
        in_valid = 1'b0;
        #2;
        checks++;
        if (acc_en !== 1'b1 || bin_valid !== 1'b0 || acc_clr !== 1'b0) begin
            failures++;
            $display("FAIL drain k=%0d en=%b bv=%b clr=%b want 1 0 0", k, acc_en, bin_valid, acc_clr);
        end
        tick();
        for (int w = 0; w < ready_wait; w++) begin
            #2;
            checks++;
            if (bin_valid !== 1'b1 || bin_index !== IW'(k) || acc_clr !== 1'b0 ||
                done !== 1'b0 || acc_en !== 1'b0) begin
                failures++;
                $display("FAIL emit_wait k=%0d w=%0d bv=%b idx=%0d clr=%b done=%b en=%b want 1 %0d 0 0 0",
                         k, w, bin_valid, bin_index, acc_clr, done, acc_en, k);
            end
            tick();
        end
        bin_ready = 1'b1;
        #2;
        checks++;
        if (bin_valid !== 1'b1 || bin_index !== IW'(k) || done !== (k == NB - 1)) begin
            failures++;
            $display("FAIL emit_handshake k=%0d bv=%b idx=%0d done=%b want 1 %0d %b",
                     k, bin_valid, bin_index, done, k, k == NB - 1);
        end
        tick();
        bin_ready = 1'b0;
    endtask

    task automatic test_addresses();
        run_bin(0, 0, -1, 1'b0);
        run_bin(1, 0, -1, 1'b0);
    endtask

    task automatic test_ena_gap();
        run_bin(2, 0, 4, 1'b0);
    endtask

    task automatic test_bin_backpressure();
        run_bin(3, 5, -1, 1'b0);
    endtask

    // Frame just finished: IDLE now, and a start in this very cycle is taken.
    task automatic test_back_to_back();
        start = 1'b1;
        #2;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bin_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_done busy=%b done=%b bv=%b want 0 0 0", busy, done, bin_valid);
        end
        tick();
        start = 1'b0;
        #2;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || buf_waddr !== '0) begin
            failures++;
            $display("FAIL restart busy=%b rdy=%b waddr=%0d want 1 1 0", busy, in_ready, buf_waddr);
        end
    endtask

    // In LOAD: 5 writes, an input gap, then an asynchronous abort and a reload.
    task automatic test_rst_mid_load();
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'b1;
            in_sample = SW'(100 + i);
            #2;
            checks++;
            if (buf_we !== 1'b1 || buf_waddr !== IW'(i)) begin
                failures++;
                $display("FAIL reload_write i=%0d we=%b waddr=%0d want 1 %0d", i, buf_we, buf_waddr, i);
            end
            tick();
        end
        in_valid = 1'b0;
        #2;
        checks++;
        if (buf_we !== 1'b0 || buf_waddr !== IW'(5) || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL load_gap we=%b waddr=%0d rdy=%b want 0 5 1", buf_we, buf_waddr, in_ready);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, buf_we, acc_clr, acc_en, bin_valid, busy, done} !== 7'b0 ||
            {buf_waddr, buf_raddr, tw_addr, bin_index} !== '0) begin
            failures++;
            $display("FAIL rst_abort strobes=%b waddr=%0d raddr=%0d tw=%0d idx=%0d want all 0",
                     {in_ready, buf_we, acc_clr, acc_en, bin_valid, busy, done},
                     buf_waddr, buf_raddr, tw_addr, bin_index);
        end
        tick();
        rst = 1'b0;
        tick();
        test_load(40);
        run_bin(0, 0, -1, 1'b1);
        run_bin(1, 2, -1, 1'b0);
    endtask

    task automatic test_twiddle_default();
        tw_k   = IW'(499);
        tw_clr = 1'b1;
        tick();
        tw_clr  = 1'b0;
        tw_step = 1'b1;
        #2;
        checks++;
        if (tw_out !== '0) begin
            failures++;
            $display("FAIL tw_full_clear tw=%0d want 0", tw_out);
        end
        for (int n = 1; n <= 999; n++) begin
            tick();
            if (n == 999) tw_step = 1'b0;
            if (n == 1 || n == 2 || n == 3 || n == 999) begin
                int want;
                case (n)
                    1:       want = 499;
                    2:       want = 998;
                    3:       want = 497;
                    default: want = 501;
                endcase
                checks++;
                if (tw_out !== IW'(want)) begin
                    failures++;
                    $display("FAIL tw_full n=%0d tw=%0d want %0d", n, tw_out, want);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load(0);
        test_addresses();
        test_ena_gap();
        test_bin_backpressure();
        test_back_to_back();
        test_rst_mid_load();
        test_twiddle_default();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
